// File: rtl/maf_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : maf_scheduler
// Description : Round-robin scheduler that shares one 32-bit fused
//               multiply-add (MAF) datapath among NUM_REQ requesters.
//               Accepts operand triples over per-requester valid/ready,
//               issues at most one op per cycle, tracks every in-flight op
//               with a tag pipeline and routes each 64-bit result back to
//               the requester that issued it.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               req_valid_i/ready_o - per-requester handshake (ready one-hot)
//               req_a/b/c_i         - packed operands, requester i at [32*i+:32]
//               maf_valid_o, maf_a/b/c_o - registered op to the MAF
//               maf_result_i        - MAF result, LATENCY cycles after issue
//               resp_valid_o        - one-hot single-cycle result strobe
//               resp_result_o       - registered result for strobed requester
//               busy_o              - op on the MAF input or in the tag pipe
//               issue_cnt_o         - ops issued since reset (wrapping)
// Revision    : 1.0 - initial release
// ============================================================================
module maf_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 2,
  parameter int IDW     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  input  logic [32*NUM_REQ-1:0]  req_a_i,
  input  logic [32*NUM_REQ-1:0]  req_b_i,
  input  logic [32*NUM_REQ-1:0]  req_c_i,
  output logic                   maf_valid_o,
  output logic [31:0]            maf_a_o,
  output logic [31:0]            maf_b_o,
  output logic [31:0]            maf_c_o,
  input  logic [63:0]            maf_result_i,
  output logic [NUM_REQ-1:0]     resp_valid_o,
  output logic [63:0]            resp_result_o,
  output logic                   busy_o,
  output logic [15:0]            issue_cnt_o
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [IDW-1:0]     rr_ptr_q;
  logic               maf_valid_q;
  logic [31:0]        maf_a_q;
  logic [31:0]        maf_b_q;
  logic [31:0]        maf_c_q;
  logic [IDW-1:0]     issue_id_q;
  logic [15:0]        issue_cnt_q;
  logic [NUM_REQ-1:0] resp_valid_q;
  logic [63:0]        resp_result_q;

  // --------------------------------------------------------------------------
  // Arbitration: first valid requester starting at rr_ptr, wrapping
  // --------------------------------------------------------------------------
  logic               grant_vld;
  logic [IDW-1:0]     grant_id;
  logic [IDW-1:0]     scan_id;
  int                 scan_int;
  logic [IDW-1:0]     rr_ptr_d;

  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    scan_id   = '0;
    scan_int  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_int = int'(rr_ptr_q) + k;
      if (scan_int >= NUM_REQ) begin
        scan_int = scan_int - NUM_REQ;
      end
      scan_id = IDW'(scan_int);
      if (!grant_vld && req_valid_i[scan_id]) begin
        grant_vld = 1'b1;
        grant_id  = scan_id;
      end
    end
    // Nothing is offered while reset is held.
    if (rst) begin
      grant_vld = 1'b0;
    end
  end

  // A grant is only ever given to a valid requester, so grant_vld is also
  // the handshake strobe.
  always_comb begin
    req_ready_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready_o[i] = grant_vld && (grant_id == IDW'(i));
    end
  end

  assign rr_ptr_d = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);

  // Operand mux for the granted requester.
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic [31:0] sel_c;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == IDW'(i)) begin
        sel_a = req_a_i[32*i +: 32];
        sel_b = req_b_i[32*i +: 32];
        sel_c = req_c_i[32*i +: 32];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Issue stage
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      maf_valid_q <= 1'b0;
      maf_a_q     <= '0;
      maf_b_q     <= '0;
      maf_c_q     <= '0;
      issue_id_q  <= '0;
      issue_cnt_q <= '0;
    end else begin
      maf_valid_q <= grant_vld;
      if (grant_vld) begin
        rr_ptr_q    <= rr_ptr_d;
        maf_a_q     <= sel_a;
        maf_b_q     <= sel_b;
        maf_c_q     <= sel_c;
        issue_id_q  <= grant_id;
        issue_cnt_q <= issue_cnt_q + 16'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Tag pipe: tail lines up with maf_result_i for the op it describes
  // --------------------------------------------------------------------------
  logic           tail_vld;
  logic [IDW-1:0] tail_id;
  logic           pipe_busy;

  generate
    if (LATENCY == 0) begin : g_bypass
      assign tail_vld  = maf_valid_q;
      assign tail_id   = issue_id_q;
      assign pipe_busy = 1'b0;
    end else begin : g_pipe
      logic [LATENCY-1:0] tag_vld_q;
      logic [IDW-1:0]     tag_id_q [LATENCY];

      always_ff @(posedge clk) begin
        if (rst) begin
          tag_vld_q <= '0;
          for (int s = 0; s < LATENCY; s++) begin
            tag_id_q[s] <= '0;
          end
        end else begin
          tag_vld_q[0] <= maf_valid_q;
          tag_id_q[0]  <= issue_id_q;
          for (int s = 1; s < LATENCY; s++) begin
            tag_vld_q[s] <= tag_vld_q[s-1];
            tag_id_q[s]  <= tag_id_q[s-1];
          end
        end
      end

      assign tail_vld  = tag_vld_q[LATENCY-1];
      assign tail_id   = tag_id_q[LATENCY-1];
      assign pipe_busy = |tag_vld_q;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Return stage
  // --------------------------------------------------------------------------
  logic [NUM_REQ-1:0] tail_onehot;

  always_comb begin
    tail_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      tail_onehot[i] = (tail_id == IDW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q  <= '0;
      resp_result_q <= '0;
    end else begin
      resp_valid_q <= tail_vld ? tail_onehot : '0;
      if (tail_vld) begin
        resp_result_q <= maf_result_i;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign maf_valid_o   = maf_valid_q;
  assign maf_a_o       = maf_a_q;
  assign maf_b_o       = maf_b_q;
  assign maf_c_o       = maf_c_q;
  assign resp_valid_o  = resp_valid_q;
  assign resp_result_o = resp_result_q;
  assign busy_o        = maf_valid_q | pipe_busy;
  assign issue_cnt_o   = issue_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_maf_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_maf_scheduler
// Description : Directed self-checking bench for maf_scheduler. Drives a
//               LATENCY=2 instance with a registered stub MAF and a
//               LATENCY=0 instance with a combinational stub MAF.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maf_scheduler;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [127:0] req_c;
  logic         stub_fixed;

  // LATENCY=2 instance
  logic [3:0]   req_ready;
  logic         maf_valid;
  logic [31:0]  maf_a;
  logic [31:0]  maf_b;
  logic [31:0]  maf_c;
  logic [63:0]  maf_result;
  logic [3:0]   resp_valid;
  logic [63:0]  resp_result;
  logic         busy;
  logic [15:0]  issue_cnt;

  // LATENCY=0 instance
  logic [3:0]   req_ready0;
  logic         maf_valid0;
  logic [31:0]  maf_a0;
  logic [31:0]  maf_b0;
  logic [31:0]  maf_c0;
  logic [63:0]  maf_result0;
  logic [3:0]   resp_valid0;
  logic [63:0]  resp_result0;
  logic         busy0;
  logic [15:0]  issue_cnt0;

  int checks;
  int errors;

  maf_scheduler #(.NUM_REQ(4), .LATENCY(2), .IDW(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .req_c_i      (req_c),
    .maf_valid_o  (maf_valid),
    .maf_a_o      (maf_a),
    .maf_b_o      (maf_b),
    .maf_c_o      (maf_c),
    .maf_result_i (maf_result),
    .resp_valid_o (resp_valid),
    .resp_result_o(resp_result),
    .busy_o       (busy),
    .issue_cnt_o  (issue_cnt)
  );

  maf_scheduler #(.NUM_REQ(4), .LATENCY(0), .IDW(2)) dut0 (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready0),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .req_c_i      (req_c),
    .maf_valid_o  (maf_valid0),
    .maf_a_o      (maf_a0),
    .maf_b_o      (maf_b0),
    .maf_c_o      (maf_c0),
    .maf_result_i (maf_result0),
    .resp_valid_o (resp_valid0),
    .resp_result_o(resp_result0),
    .busy_o       (busy0),
    .issue_cnt_o  (issue_cnt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-cycle stub MAF: result = {A, B^C}, or a fixed value when requested.
  logic [95:0] stub_s1;
  logic [95:0] stub_s2;
  always @(posedge clk) begin
    stub_s1 <= {maf_a, maf_b, maf_c};
    stub_s2 <= stub_s1;
  end
  assign maf_result  = stub_fixed ? 64'h1234 : {stub_s2[95:64], stub_s2[63:32] ^ stub_s2[31:0]};
  assign maf_result0 = {maf_a0, maf_b0 ^ maf_c0};

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_c[32*i +: 32] = c;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 4'b1111;
    tick();
    tick();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    checks++; if (req_ready0 !== 4'b0000) begin errors++; $display("FAIL reset_ready0 got=%b exp=0000", req_ready0); end
    checks++; if (maf_valid !== 1'b0) begin errors++; $display("FAIL reset_maf_valid got=%b exp=0", maf_valid); end
    checks++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0000", resp_valid); end
    checks++; if (issue_cnt !== 16'd0) begin errors++; $display("FAIL reset_issue_cnt got=%0d exp=0", issue_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (resp_result !== 64'd0) begin errors++; $display("FAIL reset_resp_result got=%h exp=0", resp_result); end
    rst       = 1'b0;
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_single_op();
    stub_fixed = 1'b1;
    set_ops(0, 32'h3F800000, 32'h40000000, 32'h0);
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
    tick();                                   // edge T+1
    req_valid = 4'b0000;
    checks++; if (maf_valid !== 1'b1) begin errors++; $display("FAIL single_maf_valid got=%b exp=1", maf_valid); end
    checks++; if (maf_a !== 32'h3F800000) begin errors++; $display("FAIL single_maf_a got=%h exp=3f800000", maf_a); end
    checks++; if (maf_b !== 32'h40000000) begin errors++; $display("FAIL single_maf_b got=%h exp=40000000", maf_b); end
    checks++; if (issue_cnt !== 16'd1) begin errors++; $display("FAIL single_issue_cnt got=%0d exp=1", issue_cnt); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
    tick();                                   // edge T+2
    checks++; if (maf_valid !== 1'b0) begin errors++; $display("FAIL single_maf_valid_drop got=%b exp=0", maf_valid); end
    checks++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL single_resp_early2 got=%b exp=0000", resp_valid); end
    tick();                                   // edge T+3
    checks++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL single_resp_early3 got=%b exp=0000", resp_valid); end
    tick();                                   // edge T+4
    checks++; if (resp_valid !== 4'b0001) begin errors++; $display("FAIL single_resp_valid got=%b exp=0001", resp_valid); end
    checks++; if (resp_result !== 64'h1234) begin errors++; $display("FAIL single_resp_result got=%h exp=1234", resp_result); end
    tick();                                   // edge T+5
    checks++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL single_resp_clear got=%b exp=0000", resp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle got=%b exp=0", busy); end
    stub_fixed = 1'b0;
  endtask

  task automatic test_fairness();
    logic [3:0] exp_ready;
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      set_ops(i, 32'h100 + i, 32'h200 + i, 32'h300 + i);
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      exp_ready = 4'b0001 << (k % 4);
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL fair_ready k=%0d got=%b exp=%b", k, req_ready, exp_ready); end
      if (k > 0) begin
        checks++; if (maf_a !== 32'h100 + 32'((k - 1) % 4)) begin errors++; $display("FAIL fair_maf_a k=%0d got=%h exp=%h", k, maf_a, 32'h100 + 32'((k - 1) % 4)); end
      end
      tick();
    end
    req_valid = 4'b0000;
    checks++; if (maf_a !== 32'h103) begin errors++; $display("FAIL fair_last_maf_a got=%h exp=103", maf_a); end
    checks++; if (issue_cnt !== 16'd8) begin errors++; $display("FAIL fair_issue_cnt got=%0d exp=8", issue_cnt); end
    repeat (4) tick();
  endtask

  task automatic test_routing();
    set_ops(2, 32'h0A02, 32'h0B02, 32'h0C02);
    set_ops(0, 32'h0A00, 32'h0B00, 32'h0C00);
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL route_ready2 got=%b exp=0100", req_ready); end
    tick();                                   // edge T+1, op from 2 issued
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL route_ready0 got=%b exp=0001", req_ready); end
    tick();                                   // edge T+2, op from 0 issued
    req_valid = 4'b0000;
    checks++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL route_resp_early got=%b exp=0000", resp_valid); end
    tick();                                   // edge T+3
    checks++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL route_resp_early3 got=%b exp=0000", resp_valid); end
    tick();                                   // edge T+4
    checks++; if (resp_valid !== 4'b0100) begin errors++; $display("FAIL route_resp_valid2 got=%b exp=0100", resp_valid); end
    checks++; if (resp_result !== 64'h00000A02_00000700) begin errors++; $display("FAIL route_result2 got=%h exp=00000a0200000700", resp_result); end
    tick();                                   // edge T+5
    checks++; if (resp_valid !== 4'b0001) begin errors++; $display("FAIL route_resp_valid0 got=%b exp=0001", resp_valid); end
    checks++; if (resp_result !== 64'h00000A00_00000700) begin errors++; $display("FAIL route_result0 got=%h exp=00000a0000000700", resp_result); end
    tick();
    checks++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL route_resp_clear got=%b exp=0000", resp_valid); end
  endtask

  task automatic test_reset_mid_flight();
    int seen;
    seen = 0;
    req_valid = 4'b1111;
    tick();
    tick();
    tick();                                   // three ops issued (1,2,3)
    req_valid = 4'b0000;
    checks++; if (maf_valid !== 1'b1) begin errors++; $display("FAIL midrst_maf_valid got=%b exp=1", maf_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (resp_valid !== 4'b0000) seen++;
      tick();
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_resp_seen got=%0d exp=0", seen); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (issue_cnt !== 16'd0) begin errors++; $display("FAIL midrst_issue_cnt got=%0d exp=0", issue_cnt); end
  endtask

  task automatic test_wrap();
    int bad;
    bad = 0;
    pulse_reset();
    set_ops(1, 32'h1, 32'h2, 32'h3);
    req_valid = 4'b0010;
    for (int k = 0; k < 65535; k++) begin
      #1;
      if (req_ready !== 4'b0010) bad++;
      tick();
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL wrap_single_grant misses=%0d exp=0", bad); end
    checks++; if (issue_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_cnt_max got=%h exp=ffff", issue_cnt); end
    tick();
    req_valid = 4'b0000;
    checks++; if (issue_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_cnt_zero got=%h exp=0000", issue_cnt); end
    repeat (4) tick();
  endtask

  task automatic test_latency0();
    pulse_reset();
    set_ops(3, 32'h0A03, 32'h0B03, 32'h0C03);
    req_valid = 4'b1000;
    #1;
    checks++; if (req_ready0 !== 4'b1000) begin errors++; $display("FAIL lat0_ready got=%b exp=1000", req_ready0); end
    tick();                                   // edge T+1
    req_valid = 4'b0000;
    checks++; if (maf_valid0 !== 1'b1) begin errors++; $display("FAIL lat0_maf_valid got=%b exp=1", maf_valid0); end
    checks++; if (resp_valid0 !== 4'b0000) begin errors++; $display("FAIL lat0_resp_early got=%b exp=0000", resp_valid0); end
    tick();                                   // edge T+2
    checks++; if (resp_valid0 !== 4'b1000) begin errors++; $display("FAIL lat0_resp_valid got=%b exp=1000", resp_valid0); end
    checks++; if (resp_result0 !== 64'h00000A03_00000700) begin errors++; $display("FAIL lat0_result got=%h exp=00000a0300000700", resp_result0); end
    tick();
    checks++; if (resp_valid0 !== 4'b0000) begin errors++; $display("FAIL lat0_resp_clear got=%b exp=0000", resp_valid0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL lat0_busy got=%b exp=0", busy0); end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    req_valid  = 4'b0000;
    req_a      = '0;
    req_b      = '0;
    req_c      = '0;
    stub_fixed = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_op();
    test_fairness();
    test_routing();
    test_reset_mid_flight();
    test_wrap();
    test_latency0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
